// File: rtl/decode_queue_if.sv
// Fetch/dispatch bundle for decode_queue. The master side is fetch plus dispatch.
// The slave side is the queue itself.
interface decode_queue_if #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int MREG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  in_valid;
  logic [31:0]           in_instr;
  logic [PC_W-1:0]       in_pc;
  logic                  in_ready;

  logic                  out_valid;
  logic                  out_ready;
  logic [PC_W-1:0]       out_pc;
  logic [1:0]            out_fu_t;
  logic [23:0]           out_ctrl;
  logic [31:0]           out_imm;
  logic [14:0]           out_regs;
  logic [4*MREG_W-1:0]   out_mregs;
  logic [4:0]            out_stride;
  logic [CNT_W-1:0]      count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_fu_t, out_ctrl, out_imm,
           out_regs, out_mregs, out_stride, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_fu_t, out_ctrl, out_imm,
           out_regs, out_mregs, out_stride, count
  );
endinterface

// File: rtl/decode_queue.sv
// Raw-instruction queue feeding a registered decode slot, with bypass, flush and HALT latch.
// Define UTYPE_DECODE_EN to decode LUI/AUIPC; otherwise they decode as illegal.
module decode_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int MREG_W = 4
) (
  input  logic           CLK,
  input  logic           RST,
  decode_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_LDM    = 7'h47;
  localparam logic [6:0] OP_STM    = 7'h57;
  localparam logic [6:0] OP_GEMM   = 7'h77;
  localparam logic [6:0] OP_HALT   = 7'h7F;

  typedef enum logic [1:0] {FU_S_T, FU_M_T, FU_G_T} fu_t_e;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, ALU_AUIPC
  } alu_op_e;
  typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} br_op_e;
  typedef enum logic [1:0] {FU_S_ALU, FU_S_BRANCH, FU_S_LD_ST} fu_s_e;
  typedef enum logic [1:0] {FU_M_NONE, FU_M_LD_ST, FU_M_GEMM} fu_m_e;
  typedef enum logic [1:0] {MEM_NONE, MEM_LOAD, MEM_STORE} mem_e;

  // The listed control fields total 23 bits, so a single zero pad fills the 24-bit bus.
  typedef struct packed {
    logic [3:0] alu_op;
    logic [2:0] branch_op;
    logic [1:0] fu_s;
    logic [1:0] fu_m;
    logic [1:0] s_mem;
    logic [1:0] m_mem;
    logic       s_reg_write;
    logic       m_reg_write;
    logic       i_flag;
    logic       jal;
    logic       jalr;
    logic       halt;
    logic       illegal;
    logic       stride_valid;
    logic       pad;
  } ctrl_t;

  typedef struct packed {
    logic [1:0]          fu_t;
    ctrl_t               ctrl;
    logic [31:0]         imm;
    logic [14:0]         regs;
    logic [4*MREG_W-1:0] mregs;
    logic [4:0]          stride;
  } dec_t;

  function automatic alu_op_e alu_sel(input logic [2:0] f3, input logic alt, input logic is_r);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic dec_t decode(input logic [31:0] i);
    dec_t        d;
    ctrl_t       c;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_m;
    f3    = i[14:12];
    imm_i = {{20{i[31]}}, i[31:20]};
    imm_m = {{22{i[17]}}, i[16:7]};
    d     = '0;
    c     = '0;
    d.fu_t  = FU_S_T;
    c.fu_s  = FU_S_ALU;
    d.regs  = {i[11:7], i[19:15], i[24:20]};
    d.mregs = {MREG_W'(i[31:28]), MREG_W'(i[27:24]), MREG_W'(i[23:20]), MREG_W'(i[19:16])};
    case (i[6:0])
      OP_RTYPE: begin
        c.alu_op      = alu_sel(f3, i[30], 1'b1);
        c.s_reg_write = 1'b1;
      end
      OP_ITYPE: begin
        c.alu_op      = alu_sel(f3, i[30], 1'b0);
        c.i_flag      = 1'b1;
        c.s_reg_write = 1'b1;
        d.imm         = imm_i;
      end
      OP_LOAD: begin
        if (f3 == 3'b010) begin
          c.fu_s        = FU_S_LD_ST;
          c.s_mem       = MEM_LOAD;
          c.s_reg_write = 1'b1;
          d.imm         = imm_i;
        end else begin
          c.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        if (f3 == 3'b010) begin
          c.fu_s  = FU_S_LD_ST;
          c.s_mem = MEM_STORE;
          d.imm   = {{20{i[31]}}, i[31:25], i[11:7]};
        end else begin
          c.illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        c.fu_s = FU_S_BRANCH;
        d.imm  = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        case (f3)
          3'b000:  c.branch_op = BR_EQ;
          3'b001:  c.branch_op = BR_NE;
          3'b100:  c.branch_op = BR_LT;
          3'b101:  c.branch_op = BR_GE;
          3'b110:  c.branch_op = BR_LTU;
          3'b111:  c.branch_op = BR_GEU;
          default: c.illegal   = 1'b1;
        endcase
      end
      OP_JAL: begin
        c.alu_op      = ALU_ADD;
        c.s_reg_write = 1'b1;
        c.jal         = 1'b1;
        d.imm         = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      OP_JALR: begin
        c.alu_op      = ALU_ADD;
        c.s_reg_write = 1'b1;
        c.jalr        = 1'b1;
        d.imm         = imm_i;
      end
      OP_LDM: begin
        d.fu_t         = FU_M_T;
        c.fu_m         = FU_M_LD_ST;
        c.m_mem        = MEM_LOAD;
        c.m_reg_write  = 1'b1;
        c.stride_valid = 1'b1;
        d.stride       = i[22:18];
        d.imm          = imm_m;
      end
      OP_STM: begin
        d.fu_t         = FU_M_T;
        c.fu_m         = FU_M_LD_ST;
        c.m_mem        = MEM_STORE;
        c.stride_valid = 1'b1;
        d.stride       = i[22:18];
        d.imm          = imm_m;
      end
      OP_GEMM: begin
        d.fu_t        = FU_G_T;
        c.fu_m        = FU_M_GEMM;
        c.m_reg_write = 1'b1;
      end
      OP_HALT: c.halt = 1'b1;
`ifdef UTYPE_DECODE_EN
      OP_LUI, OP_AUIPC: begin
        c.alu_op      = (i[6:0] == OP_LUI) ? ALU_LUI : ALU_AUIPC;
        c.s_reg_write = 1'b1;
        d.imm         = {i[31:12], 12'b0};
      end
`else
      OP_LUI, OP_AUIPC: c.illegal = 1'b1;
`endif
      default: c.illegal = 1'b1;
    endcase
    // An illegal word still dispatches, but must never write architectural state.
    if (c.illegal) begin
      c.s_reg_write = 1'b0;
      c.m_reg_write = 1'b0;
      c.s_mem       = MEM_NONE;
      c.m_mem       = MEM_NONE;
    end
    d.ctrl = c;
    return d;
  endfunction

  logic [31:0]      r_q_instr [DEPTH];
  logic [PC_W-1:0]  r_q_pc    [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_halted;
  logic             r_live;
  logic             r_out_valid;
  logic [PC_W-1:0]  r_out_pc;
  dec_t             r_out_dec;

  logic             w_q_empty;
  logic             w_q_full;
  logic             w_in_ready;
  logic             w_push;
  logic             w_slot_free;
  logic             w_load;
  logic             w_pop;
  logic             w_enq;
  logic             w_halt_push;
  logic [31:0]      w_src_instr;
  logic [PC_W-1:0]  w_src_pc;
  dec_t             w_dec;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_q_empty   = (r_count == '0);
    w_q_full    = (r_count == CNT_W'(DEPTH));
    w_in_ready  = r_live && !w_q_full && !r_halted && !bus.flush;
    w_push      = bus.in_valid && w_in_ready;
    w_halt_push = w_push && (bus.in_instr[6:0] == OP_HALT);
    w_slot_free = !r_out_valid || bus.out_ready;
    w_load      = w_slot_free && (!w_q_empty || w_push);
    w_pop       = w_load && !w_q_empty;
    // An empty queue hands the pushed word straight to the slot instead of storing it.
    w_enq       = w_push && !(w_q_empty && w_load);
    w_src_instr = w_q_empty ? bus.in_instr : r_q_instr[r_rd_ptr];
    w_src_pc    = w_q_empty ? bus.in_pc    : r_q_pc[r_rd_ptr];
    w_dec       = decode(w_src_instr);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_halted    <= 1'b0;
      r_live      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_pc    <= '0;
      r_out_dec   <= '0;
    end else begin
      r_live <= 1'b1;
      if (bus.flush) begin
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_count     <= '0;
        r_halted    <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_pc    <= '0;
        r_out_dec   <= '0;
      end else begin
        if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_pop);
        if (w_halt_push) r_halted <= 1'b1;
        if (w_load) begin
          r_out_valid <= 1'b1;
          r_out_pc    <= w_src_pc;
          r_out_dec   <= w_dec;
        end else if (w_slot_free) begin
          r_out_valid <= 1'b0;
          r_out_pc    <= '0;
          r_out_dec   <= '0;
        end
      end
    end
  end

  // NOTE: queue storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_q_instr[r_wr_ptr] <= bus.in_instr;
      r_q_pc[r_wr_ptr]    <= bus.in_pc;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_pc     = r_out_pc;
  assign bus.out_fu_t   = r_out_dec.fu_t;
  assign bus.out_ctrl   = r_out_dec.ctrl;
  assign bus.out_imm    = r_out_dec.imm;
  assign bus.out_regs   = r_out_dec.regs;
  assign bus.out_mregs  = r_out_dec.mregs;
  assign bus.out_stride = r_out_dec.stride;
  assign bus.count      = r_count;
endmodule
